// File: rtl/mm_regfile.sv
// mm_regfile -- memory-mapped register file with a waitrequest handshake.
//
// Each register resets to its own index (truncated/zero-extended to
// DATA_WIDTH). Every access passes through IDLE, then WAIT_CYCLES wait
// states, then a one-cycle ACK. Reads load readdata on the edge entering
// ACK. Writes commit on the edge leaving ACK.
//
// Parameters:
//   ADDR_WIDTH   word address width
//   DATA_WIDTH   data bus width (a multiple of 8 with byte enables)
//   DEPTH        number of registers, 1..2**ADDR_WIDTH
//   WAIT_CYCLES  extra wait states per access, 0..255
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   address      word address, sampled while read or write is high
//   read, write  commands; write wins when both are high
//   writedata    write data
//   byteenable   per-byte write lane enables (MM_REGFILE_BYTEENABLE_EN only)
//   readdata     registered read data; holds until the next read
//   waitrequest  combinational stall; the master holds its command while high
//
// Optional feature: define MM_REGFILE_BYTEENABLE_EN to add the byteenable port.
module mm_regfile #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] writedata,
`ifdef MM_REGFILE_BYTEENABLE_EN
   input  logic [DATA_WIDTH/8-1:0] byteenable,
`endif
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  waitrequest
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = 8;
   // Counter preload on entry to WAIT; unused when WAIT_CYCLES is 0
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      WAIT = 2'd2,
      ACK  = 2'd3
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [DATA_WIDTH-1:0]  regs [DEPTH];
   logic                   cmd;
   logic                   in_range;
   logic [IDX_W-1:0]       idx;
   logic [DATA_WIDTH-1:0]  wr_word;
   logic [DATA_WIDTH-1:0]  rd_word;
   logic                   rd_only;

   assign cmd      = read | write;
   assign rd_only  = read & ~write;
   assign in_range = {1'b0, address} < (ADDR_WIDTH+1)'(DEPTH);
   assign idx      = address[IDX_W-1:0];
   assign rd_word  = in_range ? regs[idx] : '0;

   // Stall in INIT and WAIT, and in IDLE as soon as a command shows up
   assign waitrequest = (state == INIT) || (state == WAIT) ||
                        ((state == IDLE) && cmd);

   // Word to store: full write, or byte-lane merge with the current contents
   always_comb begin
      wr_word = writedata;
`ifdef MM_REGFILE_BYTEENABLE_EN
      wr_word = regs[idx];
      for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
         if (byteenable[b]) begin
            wr_word[b*8 +: 8] = writedata[b*8 +: 8];
         end
      end
`endif
   end

   // Handshake FSM, wait-state counter, read data and register storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= INIT;
         cnt      <= '0;
         readdata <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= DATA_WIDTH'(i);
         end
      end else begin
         case (state)
            INIT: state <= IDLE;
            IDLE: begin
               if (cmd) begin
                  if (WAIT_CYCLES == 0) begin
                     state <= ACK;
                     if (rd_only) readdata <= rd_word;
                  end else begin
                     state <= WAIT;
                     cnt   <= WAIT_LOAD;
                  end
               end
            end
            WAIT: begin
               // A withdrawn command abandons the access
               if (!cmd) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == '0) begin
                  state <= ACK;
                  if (rd_only) readdata <= rd_word;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ACK: begin
               state <= IDLE;
               if (write && in_range) regs[idx] <= wr_word;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_regfile.sv
module tb_mm_regfile;

   logic clk;
   int   checks = 0;
   int   passed = 0;

   // DUT A: default parameters. DUT B: three wait states, 16 registers.
   logic        a_rst, a_rd, a_wr, a_wait;
   logic [7:0]  a_addr;
   logic [15:0] a_wd, a_rdata;
   logic        b_rst, b_rd, b_wr, b_wait;
   logic [7:0]  b_addr;
   logic [15:0] b_wd, b_rdata;
`ifdef MM_REGFILE_BYTEENABLE_EN
   logic [1:0]  a_be, b_be;
`endif

   logic [15:0] model_a [256];
   logic [15:0] model_b [16];
   logic [15:0] sb_q [$];

   mm_regfile dut_a (
      .clk(clk), .reset(a_rst), .address(a_addr), .read(a_rd), .write(a_wr),
      .writedata(a_wd),
`ifdef MM_REGFILE_BYTEENABLE_EN
      .byteenable(a_be),
`endif
      .readdata(a_rdata), .waitrequest(a_wait)
   );

   mm_regfile #(.WAIT_CYCLES(3), .DEPTH(16)) dut_b (
      .clk(clk), .reset(b_rst), .address(b_addr), .read(b_rd), .write(b_wr),
      .writedata(b_wd),
`ifdef MM_REGFILE_BYTEENABLE_EN
      .byteenable(b_be),
`endif
      .readdata(b_rdata), .waitrequest(b_wait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                         input logic [1:0] be);
      logic [15:0] r;
      r = o;
      for (int b = 0; b < 2; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   // One bus access: drive, count stalled cycles, score the read in ACK, release
   task automatic access(input bit sel, input bit rd, input bit wr, input logic [7:0] addr,
                         input logic [15:0] data, input logic [1:0] be,
                         output int hi, output logic [15:0] rdata);
      logic [15:0] exp;
      logic [1:0]  eff;
      @(negedge clk);
      if (sel) begin
         b_addr = addr; b_rd = rd; b_wr = wr; b_wd = data;
`ifdef MM_REGFILE_BYTEENABLE_EN
         b_be = be;
`endif
      end else begin
         a_addr = addr; a_rd = rd; a_wr = wr; a_wd = data;
`ifdef MM_REGFILE_BYTEENABLE_EN
         a_be = be;
`endif
      end
      if (rd && !wr) begin
         if (sel) sb_q.push_back((addr < 8'd16) ? model_b[addr[3:0]] : 16'h0000);
         else     sb_q.push_back(model_a[addr]);
      end
      hi = 0;
      #1;
      while (((sel ? b_wait : a_wait) === 1'b1) && hi < 300) begin
         hi++;
         @(negedge clk);
         #1;
      end
      if (hi >= 300) begin
         checks++;
         $display("FAIL access_timeout: waitrequest still %b after %0d cycles, required 0",
                  sel ? b_wait : a_wait, hi);
      end
      rdata = sel ? b_rdata : a_rdata;
      if (rd && !wr && sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         checks++;
         if (rdata !== exp)
            $display("FAIL scoreboard_read dut=%0d addr=%0d: got %h, required %h",
                     sel, addr, rdata, exp);
         else passed++;
      end
`ifdef MM_REGFILE_BYTEENABLE_EN
      eff = be;
`else
      eff = 2'b11;
`endif
      if (wr) begin
         if (sel) begin
            if (addr < 8'd16) model_b[addr[3:0]] = merge(model_b[addr[3:0]], data, eff);
         end else begin
            model_a[addr] = merge(model_a[addr], data, eff);
         end
      end
      @(posedge clk);
      #1;
      if (sel) begin b_rd = 1'b0; b_wr = 1'b0; end
      else     begin a_rd = 1'b0; a_wr = 1'b0; end
   endtask

   task automatic test_reset(input bit sel);
      @(negedge clk);
      if (sel) begin b_rst = 1'b1; b_rd = 1'b0; b_wr = 1'b0; end
      else     begin a_rst = 1'b1; a_rd = 1'b0; a_wr = 1'b0; end
      if (sel) for (int i = 0; i < 16; i++) model_b[i] = 16'(i);
      else     for (int i = 0; i < 256; i++) model_a[i] = 16'(i);
      #1;
      checks++;
      if ((sel ? b_wait : a_wait) !== 1'b1)
         $display("FAIL reset_wait dut=%0d: got %b, required 1", sel, sel ? b_wait : a_wait);
      else passed++;
      checks++;
      if ((sel ? b_rdata : a_rdata) !== 16'h0000)
         $display("FAIL reset_rdata dut=%0d: got %h, required 0000", sel, sel ? b_rdata : a_rdata);
      else passed++;
      @(negedge clk);
      if (sel) b_rst = 1'b0; else a_rst = 1'b0;
      #1;
      checks++;
      if ((sel ? b_wait : a_wait) !== 1'b1)
         $display("FAIL init_wait dut=%0d: got %b, required 1", sel, sel ? b_wait : a_wait);
      else passed++;
      @(negedge clk);
      #1;
      checks++;
      if ((sel ? b_wait : a_wait) !== 1'b0)
         $display("FAIL idle_wait dut=%0d: got %b, required 0", sel, sel ? b_wait : a_wait);
      else passed++;
   endtask

   task automatic test_default_read();
      int hi; logic [15:0] rd;
      access(1'b0, 1'b1, 1'b0, 8'd1, 16'h0, 2'b11, hi, rd);
      checks++;
      if (hi !== 1) $display("FAIL read_latency: got %0d stall cycles, required 1", hi);
      else passed++;
      checks++;
      if (rd !== 16'h0001) $display("FAIL read_default: got %h, required 0001", rd);
      else passed++;
   endtask

   task automatic test_write_read();
      int hi; logic [15:0] rd;
      access(1'b0, 1'b0, 1'b1, 8'd1, 16'hBEEF, 2'b11, hi, rd);
      access(1'b0, 1'b1, 1'b0, 8'd1, 16'h0, 2'b11, hi, rd);
      checks++;
      if (rd !== 16'hBEEF) $display("FAIL write_read: got %h, required beef", rd);
      else passed++;
      access(1'b0, 1'b1, 1'b0, 8'd2, 16'h0, 2'b11, hi, rd);
      checks++;
      if (rd !== 16'h0002) $display("FAIL read_addr2: got %h, required 0002", rd);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int hi; logic [15:0] rd;
      for (int k = 0; k < 2; k++) begin
         access(1'b0, 1'b1, 1'b0, 8'd3, 16'h0, 2'b11, hi, rd);
         checks++;
         if (rd !== 16'h0003 || hi !== 1)
            $display("FAIL b2b_read%0d: got %h/%0d, required 0003/1", k, rd, hi);
         else passed++;
      end
   endtask

   task automatic test_wait_states();
      int hi; logic [15:0] rd;
      access(1'b1, 1'b1, 1'b0, 8'd5, 16'h0, 2'b11, hi, rd);
      checks++;
      if (hi !== 4) $display("FAIL wait_latency: got %0d stall cycles, required 4", hi);
      else passed++;
      checks++;
      if (rd !== 16'h0005) $display("FAIL wait_read: got %h, required 0005", rd);
      else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (b_wait !== 1'b0) $display("FAIL wait_idle_after: got %b, required 0", b_wait);
      else passed++;
   endtask

   task automatic test_out_of_range();
      int hi; logic [15:0] rd;
      access(1'b1, 1'b0, 1'b1, 8'd20, 16'h1234, 2'b11, hi, rd);
      checks++;
      if (hi !== 4) $display("FAIL oor_write_latency: got %0d, required 4", hi);
      else passed++;
      access(1'b1, 1'b1, 1'b0, 8'd20, 16'h0, 2'b11, hi, rd);
      checks++;
      if (rd !== 16'h0000) $display("FAIL oor_read: got %h, required 0000", rd);
      else passed++;
      access(1'b1, 1'b1, 1'b0, 8'd4, 16'h0, 2'b11, hi, rd);
      checks++;
      if (rd !== 16'h0004) $display("FAIL oor_alias: got %h, required 0004", rd);
      else passed++;
   endtask

   task automatic test_byteenable();
      int hi; logic [15:0] rd, exp;
`ifdef MM_REGFILE_BYTEENABLE_EN
      exp = 16'hAA07;
`else
      exp = 16'hAABB;
`endif
      access(1'b0, 1'b0, 1'b1, 8'd7, 16'hAABB, 2'b10, hi, rd);
      access(1'b0, 1'b1, 1'b0, 8'd7, 16'h0, 2'b11, hi, rd);
      checks++;
      if (rd !== exp) $display("FAIL byteenable: got %h, required %h", rd, exp);
      else passed++;
   endtask

   task automatic test_read_write_both();
      int hi; logic [15:0] rd;
      access(1'b0, 1'b1, 1'b0, 8'd2, 16'h0, 2'b11, hi, rd);
      access(1'b0, 1'b1, 1'b1, 8'd3, 16'h5555, 2'b11, hi, rd);
      checks++;
      if (rd !== 16'h0002) $display("FAIL rw_hold_rdata: got %h, required 0002", rd);
      else passed++;
      access(1'b0, 1'b1, 1'b0, 8'd3, 16'h0, 2'b11, hi, rd);
      checks++;
      if (rd !== 16'h5555) $display("FAIL rw_is_write: got %h, required 5555", rd);
      else passed++;
   endtask

   task automatic test_withdraw();
      int hi; logic [15:0] rd;
      @(negedge clk);
      b_addr = 8'd6; b_wd = 16'h7777; b_wr = 1'b1;
      @(negedge clk);
      b_wr = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (b_wait !== 1'b0) $display("FAIL withdraw_idle: got %b, required 0", b_wait);
      else passed++;
      access(1'b1, 1'b1, 1'b0, 8'd6, 16'h0, 2'b11, hi, rd);
      checks++;
      if (rd !== 16'h0006) $display("FAIL withdraw_nowrite: got %h, required 0006", rd);
      else passed++;
   endtask

   task automatic test_reset_mid_access();
      int hi; logic [15:0] rd;
      @(negedge clk);
      b_addr = 8'd9; b_wd = 16'hFFFF; b_wr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      b_rst = 1'b1; b_wr = 1'b0;
      for (int i = 0; i < 16; i++) model_b[i] = 16'(i);
      #1;
      checks++;
      if (b_wait !== 1'b1) $display("FAIL midreset_wait: got %b, required 1", b_wait);
      else passed++;
      @(negedge clk);
      b_rst = 1'b0;
      @(negedge clk);
      access(1'b1, 1'b1, 1'b0, 8'd9, 16'h0, 2'b11, hi, rd);
      checks++;
      if (rd !== 16'h0009) $display("FAIL midreset_nowrite: got %h, required 0009", rd);
      else passed++;
   endtask

   task automatic test_random();
      int hi; logic [15:0] rd;
      for (int k = 0; k < 24; k++) begin
         access(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 15)), 16'($urandom), 2'b11, hi, rd);
         access(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 15)), 16'h0, 2'b11, hi, rd);
      end
   endtask

   initial begin
      a_rst = 1'b1; a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wd = '0;
      b_rst = 1'b1; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wd = '0;
`ifdef MM_REGFILE_BYTEENABLE_EN
      a_be = 2'b11; b_be = 2'b11;
`endif
      test_reset(1'b0);
      test_reset(1'b1);
      test_default_read();
      test_write_read();
      test_back_to_back();
      test_wait_states();
      test_out_of_range();
      test_byteenable();
      test_read_write_both();
      test_withdraw();
      test_reset_mid_access();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mm_regfile.md
MM_REGFILE -- requirements
Module: mm_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data bus width; a multiple of 8 when MM_REGFILE_BYTEENABLE_EN is defined.
REQ-003 SHALL have parameter DEPTH, default 256, number of registers, 1..2**ADDR_WIDTH.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, extra wait states per access, 0..255.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk input 1, sole clock, rising edge; reset input 1, async active-high.
REQ-006 address  input  ADDR_WIDTH  word address, sampled while read or write is high.
REQ-007 read  input  1  read command.
REQ-008 write  input  1  write command.
REQ-009 writedata  input  DATA_WIDTH  write data.
REQ-010 readdata  output  DATA_WIDTH  registered read data.
REQ-011 waitrequest  output  1  slave stall; the master holds the command while it is high.

Function
REQ-012 SHALL implement states INIT, IDLE, WAIT and ACK with a WAIT_CYCLES down-counter.
REQ-013 INIT -> IDLE on the first clk edge after reset deasserts.
REQ-014 IDLE -> WAIT when read|write is high and WAIT_CYCLES>0; IDLE -> ACK when read|write is high and WAIT_CYCLES=0; otherwise stay in IDLE.
REQ-015 WAIT SHALL last exactly WAIT_CYCLES cycles, then go to ACK.
REQ-016 ACK -> IDLE unconditionally; back-to-back commands re-enter through IDLE.
REQ-017 waitrequest SHALL be combinational.
REQ-018 waitrequest SHALL be high in INIT.
REQ-019 waitrequest SHALL be high in WAIT.
REQ-020 waitrequest SHALL be high in IDLE when read|write is high.
REQ-021 waitrequest SHALL be low in ACK, and in IDLE with no command.
REQ-022 Latency: command first seen in cycle 0 -> waitrequest high for WAIT_CYCLES+1 cycles, low in cycle WAIT_CYCLES+1 (ACK); the command is accepted at the end of the ACK cycle.
REQ-023 Read: readdata SHALL be loaded on the edge entering ACK with reg[address], and hold until the next read.
REQ-024 Write: reg[address] SHALL be updated on the edge leaving ACK.
REQ-025 Out-of-range address (address >= DEPTH): a read SHALL return 0, a write SHALL be ignored, and the handshake SHALL be unchanged.
REQ-026 read and write both high: the access SHALL be a write; readdata SHALL be unchanged.
REQ-027 Command withdrawn in WAIT or ACK (read=write=0, a protocol violation): the state SHALL return to IDLE with no register update.
REQ-028 Width rule: the reset value of reg[i] SHALL be i zero-extended or truncated to DATA_WIDTH.

Reset
REQ-029 On reset, state = INIT, waitrequest = 1, readdata = 0, counter = 0, and reg[i] = i for all i < DEPTH.
REQ-030 Reset asserted mid-access SHALL abort the access with no write, and the block re-enters INIT.

Configuration
REQ-031 Macro MM_REGFILE_BYTEENABLE_EN defined: the block SHALL add the port byteenable, input, DATA_WIDTH/8 bits, and a write SHALL update only the byte lanes whose bit is set.
REQ-032 Without MM_REGFILE_BYTEENABLE_EN: there SHALL be no byteenable port, and every write SHALL update all DATA_WIDTH bits.

Verification
REQ-033 Reset release, defaults: waitrequest=1 during reset and the first cycle after; read addr 1 -> waitrequest high 1 cycle then low, readdata=16'h0001.
REQ-034 Write addr 1 data 16'hBEEF, then read addr 1 -> readdata=16'hBEEF; read addr 2 -> 16'h0002; read addr 3 twice back-to-back -> 16'h0003 both times.
REQ-035 WAIT_CYCLES=3: read addr 5 -> waitrequest high exactly 4 cycles, low 1 cycle, readdata=16'h0005.
REQ-036 DEPTH=16: write addr 20 data 16'h1234, then read addr 20 -> 16'h0000; reg[4] is still 16'h0004.
REQ-037 MM_REGFILE_BYTEENABLE_EN defined, byteenable=2'b10: write 16'hAABB to addr 7 -> read returns 16'hAA07; without the macro, the same write returns 16'hAABB.
REQ-038 WAIT_CYCLES=3: assert reset in the second WAIT cycle of a write of 16'hFFFF to addr 9 -> read addr 9 after reset returns 16'h0009.
